pif_layer_scheduler: RTL and testbench

- Time-multiplexes one shared signed PIF full-neuron datapath across all neurons of a layer.
- For each neuron in turn it:
  - reads the stored membrane potential;
  - holds the neuron datapath in reset, then releases it;
  - streams that neuron's weights into the datapath, inserting zero weights during stalls;
  - asserts finished and waits for the integrate/fire update;
  - writes back the new potential and records the spike bit.
- Sits between the layer memories (vmem RAM, weight stream source) and the full-neuron instance.

---
 rtl/pif_layer_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_pif_layer_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pif_layer_scheduler.sv
// Sequences one shared PIF full-neuron datapath across every neuron of a layer.
// Per neuron: RD, CAP, ARM, stream cycles + 1, FINISH_CYCLES of FIN, then WB.
// Weights are taken only when the neuron reports readyMem; otherwise a zero weight is presented.
module pif_layer_scheduler #(
  parameter int DATA_WIDTH     = 16,
  parameter int FRACTION_WIDTH = 8,
  parameter int NUM_NEURONS    = 64,
  parameter int ADDR_W         = 6,
  parameter int CNT_W          = 10,
  parameter int FINISH_CYCLES  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_inputs,
  output logic                      busy,
  output logic                      done,
  output logic                      vmem_re,
  output logic [ADDR_W-1:0]         vmem_raddr,
  input  logic [DATA_WIDTH-1:0]     vmem_rdata,
  output logic                      vmem_we,
  output logic [ADDR_W-1:0]         vmem_waddr,
  output logic [DATA_WIDTH-1:0]     vmem_wdata,
  input  logic                      wt_valid,
  input  logic [FRACTION_WIDTH-1:0] wt_data,
  output logic                      wt_ready,
  output logic                      neur_reset_n,
  output logic                      neur_finished,
  output logic [DATA_WIDTH-1:0]     neur_vmem_in,
  output logic [FRACTION_WIDTH-1:0] neur_weight,
  input  logic                      neur_ready_mem,
  input  logic [DATA_WIDTH-1:0]     neur_vmem_out,
  input  logic                      neur_spike,
  output logic [NUM_NEURONS-1:0]    spike_vec
);

  // Down-counter width for the FIN hold; reload value is FINISH_CYCLES-1 so
  // that the count reaching zero marks the last FIN cycle.
  localparam int              FC_W    = (FINISH_CYCLES > 1) ? $clog2(FINISH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FINISH_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_ARM,
    S_STRM,
    S_FIN,
    S_WB,
    S_DONE
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [ADDR_W-1:0]       idx;
  logic [CNT_W-1:0]        num_lat;
  logic [CNT_W-1:0]        wcnt;
  logic [FC_W-1:0]         fcnt;
  logic [DATA_WIDTH-1:0]   cap_vmem;
  logic                    cap_spike;
  logic                    wt_fire;

  // Weight handshake: only meaningful while streaming, since wt_ready is low elsewhere.
  assign wt_fire = wt_valid & wt_ready;

  // Read and write both target the neuron currently being processed.
  assign vmem_raddr = idx;
  assign vmem_waddr = idx;
  assign vmem_wdata = cap_vmem;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    state_nx      = state;
    busy          = 1'b0;
    done          = 1'b0;
    vmem_re       = 1'b0;
    vmem_we       = 1'b0;
    wt_ready      = 1'b0;
    neur_reset_n  = 1'b0;
    neur_finished = 1'b0;
    neur_weight   = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_RD;
        end
      end
      S_RD: begin
        busy     = 1'b1;
        vmem_re  = 1'b1;
        state_nx = S_CAP;
      end
      S_CAP: begin
        busy     = 1'b1;
        state_nx = S_ARM;
      end
      S_ARM: begin
        busy         = 1'b1;
        neur_reset_n = 1'b1;
        state_nx     = (num_lat == '0) ? S_FIN : S_STRM;
      end
      S_STRM: begin
        busy         = 1'b1;
        neur_reset_n = 1'b1;
        wt_ready     = neur_ready_mem & (wcnt < num_lat);
        // A zero weight is a no-op add, so stalls leave the sum untouched.
        if (wt_valid && wt_ready) begin
          neur_weight = wt_data;
        end
        if (wcnt == num_lat) begin
          state_nx = S_FIN;
        end
      end
      S_FIN: begin
        busy          = 1'b1;
        neur_reset_n  = 1'b1;
        neur_finished = 1'b1;
        if (fcnt == '0) begin
          state_nx = S_WB;
        end
      end
      S_WB: begin
        busy     = 1'b1;
        vmem_we  = 1'b1;
        state_nx = (idx == LAST_IDX) ? S_DONE : S_RD;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Pass bookkeeping: latched input count and the neuron index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      num_lat <= '0;
      idx     <= '0;
    end else if (state == S_IDLE && start) begin
      num_lat <= num_inputs;
      idx     <= '0;
    end else if (state == S_WB && idx != LAST_IDX) begin
      idx <= idx + ADDR_W'(1);
    end
  end

  // Capture the stored potential; it stays on neur_vmem_in until the next neuron's CAP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      neur_vmem_in <= '0;
    end else if (state == S_CAP) begin
      neur_vmem_in <= vmem_rdata;
    end
  end

  // Count accepted weights for the current neuron.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wcnt <= '0;
    end else if (state == S_CAP) begin
      wcnt <= '0;
    end else if (state == S_STRM && wt_fire) begin
      wcnt <= wcnt + CNT_W'(1);
    end
  end

  // FIN hold counter: reloaded outside FIN, counts down while finished is asserted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fcnt <= FC_LOAD;
    end else if (state != S_FIN) begin
      fcnt <= FC_LOAD;
    end else if (fcnt != '0) begin
      fcnt <= fcnt - FC_W'(1);
    end
  end

  // Sample the neuron result in the last FIN cycle, when the update has settled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cap_vmem  <= '0;
      cap_spike <= 1'b0;
    end else if (state == S_FIN && fcnt == '0) begin
      cap_vmem  <= neur_vmem_out;
      cap_spike <= neur_spike;
    end
  end

  // Spike record: cleared on an accepted start, one bit filled in per writeback.
  always_ff @(posedge clk) begin
    if (!reset) begin
      spike_vec <= '0;
    end else if (state == S_IDLE && start) begin
      spike_vec <= '0;
    end else if (state == S_WB) begin
      spike_vec[idx] <= cap_spike;
    end
  end

endmodule

// File: tb/tb_pif_layer_scheduler.sv
// Bench for pif_layer_scheduler: behavioural vmem RAM, an accumulate-style
// neuron stand-in, random weight source and a scoreboard of expected writebacks.
module tb_pif_layer_scheduler;

  localparam int DW = 16;
  localparam int FW = 8;
  localparam int NN = 3;
  localparam int AW = 2;
  localparam int CW = 10;
  localparam int FC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] num_inputs;
  logic          busy, done;
  logic          vmem_re, vmem_we;
  logic [AW-1:0] vmem_raddr, vmem_waddr;
  logic [DW-1:0] vmem_rdata, vmem_wdata;
  logic          wt_valid, wt_ready;
  logic [FW-1:0] wt_data;
  logic          neur_reset_n, neur_finished, neur_ready_mem, neur_spike;
  logic [DW-1:0] neur_vmem_in, neur_vmem_out;
  logic [FW-1:0] neur_weight;
  logic [NN-1:0] spike_vec;

  pif_layer_scheduler #(
    .DATA_WIDTH(DW), .FRACTION_WIDTH(FW), .NUM_NEURONS(NN),
    .ADDR_W(AW), .CNT_W(CW), .FINISH_CYCLES(FC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_inputs(num_inputs),
    .busy(busy), .done(done),
    .vmem_re(vmem_re), .vmem_raddr(vmem_raddr), .vmem_rdata(vmem_rdata),
    .vmem_we(vmem_we), .vmem_waddr(vmem_waddr), .vmem_wdata(vmem_wdata),
    .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
    .neur_reset_n(neur_reset_n), .neur_finished(neur_finished),
    .neur_vmem_in(neur_vmem_in), .neur_weight(neur_weight),
    .neur_ready_mem(neur_ready_mem), .neur_vmem_out(neur_vmem_out),
    .neur_spike(neur_spike), .spike_vec(spike_vec)
  );

  always #5 clk = ~clk;

  // vmem RAM with one-cycle read latency and a bench-side init port.
  logic [DW-1:0] ram [NN];
  logic          init_we;
  logic [AW-1:0] init_addr;
  logic [DW-1:0] init_data;
  always_ff @(posedge clk) begin
    if (vmem_we) ram[vmem_waddr] <= vmem_wdata;
    else if (init_we) ram[init_addr] <= init_data;
    if (vmem_re) vmem_rdata <= ram[vmem_raddr];
  end

  // Neuron stand-in: accumulates sign-extended weights while out of reset.
  logic [DW-1:0] acc;
  always_ff @(posedge clk) begin
    if (!neur_reset_n) acc <= '0;
    else acc <= acc + {{(DW-FW){neur_weight[FW-1]}}, neur_weight};
  end
  assign neur_vmem_out = neur_vmem_in + acc;
  assign neur_spike    = ($signed(neur_vmem_out) > 0);

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int nw; } wb_t;
  wb_t           wb_q[$];
  logic [NN-1:0] spk_q[$];
  logic [FW-1:0] src_q[$];
  logic [DW-1:0] model_mem [NN];

  int n_total = 0;
  int n_pass  = 0;
  int done_cnt = 0, we_cnt = 0, hs_cnt = 0, fin_cnt = 0;
  bit hs_last = 0, rule_err = 0, toggle_mode = 0, tog = 0;
  int vpct = 100, rpct = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Weight source and readyMem driver; pops the head after each handshake.
  initial begin
    wt_valid = 0; wt_data = 0; neur_ready_mem = 1;
    forever begin
      @(posedge clk); #1;
      if (hs_last && src_q.size() > 0) void'(src_q.pop_front());
      tog = ~tog;
      if (src_q.size() > 0) begin
        wt_data  = src_q[0];
        wt_valid = toggle_mode ? tog : ($urandom_range(99) < vpct);
      end else begin
        wt_valid = 0; wt_data = 0;
      end
      neur_ready_mem = ($urandom_range(99) < rpct);
    end
  end

  // Monitor: stream rules every cycle, writebacks and done pulses against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        hs_last = 0; hs_cnt = 0; fin_cnt = 0; rule_err = 0;
      end else begin
        hs_last = wt_valid & wt_ready;
        if (hs_last) begin
          hs_cnt++;
          if (neur_weight !== wt_data) rule_err = 1;
        end else if (neur_weight !== '0) rule_err = 1;
        if (wt_ready && !neur_ready_mem) rule_err = 1;
        if (neur_finished) fin_cnt++;
        if (vmem_we) begin
          we_cnt++;
          if (wb_q.size() == 0) begin
            check("unexpected_wb", 1, 0);
          end else begin
            wb_t e;
            e = wb_q.pop_front();
            check("wb_addr", vmem_waddr, e.addr);
            check("wb_data", vmem_wdata, e.data);
            check("handshakes", hs_cnt, e.nw);
            check("fin_cycles", fin_cnt, FC);
            check("stream_rules", rule_err, 0);
          end
          hs_cnt = 0; fin_cnt = 0; rule_err = 0;
        end
        if (done) begin
          done_cnt++;
          check("busy_at_done", busy, 0);
          if (spk_q.size() == 0) check("unexpected_done", 1, 0);
          else check("spike_vec", spike_vec, spk_q.pop_front());
        end
      end
    end
  end

  // Reference: each neuron consumes the next num weights; new vmem = old + sum; spikes if positive.
  task automatic prepare(input int num);
    logic [NN-1:0] sv;
    sv = '0;
    for (int n = 0; n < NN; n++) begin
      logic [DW-1:0] sum;
      wb_t e;
      sum = '0;
      for (int k = 0; k < num; k++) begin
        logic [FW-1:0] w;
        w = FW'($urandom);
        src_q.push_back(w);
        sum = sum + {{(DW-FW){w[FW-1]}}, w};
      end
      model_mem[n] = model_mem[n] + sum;
      e.addr = AW'(n); e.data = model_mem[n]; e.nw = num;
      wb_q.push_back(e);
      sv[n] = ($signed(model_mem[n]) > 0);
    end
    spk_q.push_back(sv);
  endtask

  task automatic kick(input int num);
    @(posedge clk); #1;
    start = 1; num_inputs = CW'(num);
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_pass(input int num, input int vp, input int rp, input bit tgl, input bit extra);
    int target;
    vpct = vp; rpct = rp; toggle_mode = tgl;
    target = done_cnt + 1;
    prepare(num);
    kick(num);
    if (extra) begin
      repeat (2) @(posedge clk);
      #1 start = 1; num_inputs = 5;
      @(posedge clk); #1 start = 0;
    end
    for (int c = 0; c < 5000 && done_cnt < target; c++) @(posedge clk);
    repeat (30) @(posedge clk);
    check("done_count", done_cnt, target);
    check("wb_queue_drained", wb_q.size(), 0);
  endtask

  initial begin
    reset = 0; start = 0; num_inputs = 0;
    init_we = 0; init_addr = 0; init_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we_re", {vmem_we, vmem_re}, 0);
    check("rst_wt_ready", wt_ready, 0);
    check("rst_finished", neur_finished, 0);
    check("rst_neur_reset_n", neur_reset_n, 0);
    check("rst_weight_vin", {neur_weight, neur_vmem_in}, 0);
    check("rst_spike_vec", spike_vec, 0);
    check("rst_addr", {vmem_raddr, vmem_waddr}, 0);
    // Neuron 1 starts positive, the others negative, so only it spikes with no weights.
    for (int i = 0; i < NN; i++) begin
      @(posedge clk); #1;
      init_we = 1; init_addr = AW'(i);
      init_data = (i == 1) ? 16'd1000 : -16'sd1000;
      model_mem[i] = init_data;
    end
    @(posedge clk); #1 init_we = 0;
    reset = 1;

    run_pass(0, 100, 100, 0, 1);   // no weights, extra start while busy
    run_pass(4, 100, 100, 0, 0);   // full-rate streaming
    run_pass(3, 100, 100, 1, 0);   // valid toggling
    run_pass(6, 70, 60, 0, 0);     // random valid and readyMem stalls
    for (int p = 0; p < 4; p++)
      run_pass($urandom_range(0, 9), $urandom_range(40, 100), $urandom_range(40, 100), 0, 0);

    // Abort mid-stream after three accepted weights.
    begin
      int we_before;
      bit seen;
      vpct = 100; rpct = 100; toggle_mode = 0;
      prepare(8);
      kick(8);
      seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(negedge clk);
        if (hs_cnt == 3) seen = 1;
      end
      check("reached_wcnt3", seen, 1);
      @(posedge clk); #1 reset = 0;
      @(posedge clk);
      @(negedge clk);
      wb_q.delete(); spk_q.delete(); src_q.delete();
      check("abort_busy", busy, 0);
      check("abort_neur_reset_n", neur_reset_n, 0);
      check("abort_wt_ready", wt_ready, 0);
      we_before = we_cnt;
      repeat (2) @(posedge clk);
      #1 reset = 1;
      repeat (40) @(posedge clk);
      check("no_wb_after_abort", we_cnt, we_before);
      for (int i = 0; i < NN; i++) model_mem[i] = ram[i];
    end

    run_pass(5, 80, 80, 0, 0);     // recovery after abort

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
